scalar_mul_feeder: RTL and testbench
====================================

// Module: scalar_mul_feeder
// PURPOSE
// - Front-end stage feeding the 300-bit pipelined mod-p reduction. The reduction is free-running with no valid signal.
// - Accepts a 256-bit field element a and a 44-bit scalar k over a valid/ready handshake.
// - Computes x = a*k (300 bits) with a fixed-latency serial shift-add multiplier.
// - Presents x to the reduction input with a one-cycle x_valid strobe.
// - Delays x_valid by the reduction latency to produce res_valid, which qualifies the reduction output o.
// PARAMETERS
// A_WIDTH         256  width of operand a (field element)
// K_WIDTH         44   width of scalar k; also the number of multiply iterations
// X_WIDTH         300  product width; must equal A_WIDTH+K_WIDTH
// REDUCE_LATENCY  45   clock edges from x sampled to o updated in the reduction pipeline
// PORTS
// clk        in   1        clock, rising edge
// reset      in   1        synchronous, active-high
// in_valid   in   1        a/k valid
// in_ready   out  1        feeder can accept a/k
// a          in   A_WIDTH  multiplicand
// k          in   K_WIDTH  scalar multiplier
// x          out  X_WIDTH  product a*k; drives the reduction input x
// x_valid    out  1        one-cycle strobe: x holds a fresh product
// busy       out  1        multiply in progress
// res_valid  out  1        one-cycle strobe: reduction output o = (a*k) mod p
// BEHAVIOUR
// - Clock and reset: reset reset, synchronous, active-high; clock clk.
// - Reset values: x=0, x_valid=0, res_valid=0, busy=0, state=IDLE, delay line all 0.
// - in_ready = (state==IDLE) && !reset. It is combinational and is 0 during reset.
// - States:
//   - IDLE: handshake fires on an edge with in_valid && in_ready.
//     - Registers: mcand <= zero-extended a (X_WIDTH), mplr <= k, acc <= 0, cnt <= 0.
//     - Next state: MUL.
//   - MUL: one iteration per edge.
//     - If mplr[0], acc += mcand. Then mcand <<= 1, mplr >>= 1, cnt++.
//     - Iteration count is always K_WIDTH. There is no early exit when mplr==0 (fixed latency).
//     - Final iteration (cnt==K_WIDTH-1): x <= acc + (mplr[0] ? mcand : 0), x_valid <= 1, next state IDLE.
// - busy = (state==MUL).
// - x_valid rises K_WIDTH edges after the accepting edge and is high for exactly 1 cycle.
// - x holds its value until the next product completes.
// - Throughput: a new handshake may fire in the same cycle x_valid is high. Back-to-back period is K_WIDTH+1 cycles.
// - in_valid while not ready is ignored; upstream holds a/k until in_ready.
// - Arithmetic: acc, mcand and x are X_WIDTH bits.
//   - Max product (2^256-1)(2^44-1) < 2^300, so no overflow.
//   - Bits shifted out of mcand beyond X_WIDTH are always 0.
// - res_valid: REDUCE_LATENCY-deep shift register of x_valid.
//   - res_valid is high exactly in the cycle where o reflects (x mod p) of that strobe.
// - Reset mid-MUL: the operation is aborted with no x_valid.
//   - The delay line is cleared, so no res_valid fires for in-flight products. This matches the reduction pipeline flush.
// - Reset and in_valid together: no handshake.
// TESTING
// - a=5, k=3 -> x=15 with x_valid 44 edges after accept; res_valid 45 edges later with o=15.
// - a=p=104899928942039473597645237135751317405745389583683433800060134911610808289117, k=1 -> x=p; at res_valid, o=0.
// - a=2^256-1, k=2^44-1 -> x=(2^256-1)*(2^44-1) exact; o equals the model's x mod p.
// - k=0, a=123 -> x=0, x_valid still exactly 44 edges after accept; o=0.
// - in_valid held high with 3 operand pairs -> accepts spaced 45 cycles apart; 3 x_valid and 3 res_valid pulses, in order, with correct values.
// - reset asserted 20 cycles into MUL -> no x_valid, no res_valid; in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/scalar_mul_feeder.sv
// scalar_mul_feeder: accepts a field element a and a scalar k and forms the
// exact product x = a*k with a fixed-latency serial shift-add multiplier. It
// strobes x_valid for one cycle when x is fresh, and delays that strobe by the
// reduction pipeline latency to produce res_valid.
module scalar_mul_feeder #(
    parameter int A_WIDTH        = 256,
    parameter int K_WIDTH        = 44,
    parameter int X_WIDTH        = 300,
    parameter int REDUCE_LATENCY = 45
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [K_WIDTH-1:0] k,
    output logic [X_WIDTH-1:0] x,
    output logic               x_valid,
    output logic               busy,
    output logic               res_valid
);

    localparam int                CNT_W    = $clog2(K_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(K_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [X_WIDTH-1:0]        mcand_q, mcand_d;
    logic [X_WIDTH-1:0]        acc_q, acc_d;
    logic [K_WIDTH-1:0]        mplr_q, mplr_d;
    logic [X_WIDTH-1:0]        x_q, x_d;
    logic                      x_valid_q, x_valid_d;
    logic [REDUCE_LATENCY-1:0] dly_q, dly_d;
    logic [X_WIDTH-1:0]        sum;
    logic                      accept;

    // Ready is suppressed during reset so an in_valid coinciding with reset never handshakes.
    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == S_MUL);
    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign res_valid = dly_q[REDUCE_LATENCY-1];

    // Next-state logic: load operands on accept, then exactly K_WIDTH shift-add
    // iterations with no early exit so the product latency never depends on k.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        x_d       = x_q;
        x_valid_d = 1'b0;
        sum       = acc_q + (mplr_q[0] ? mcand_q : '0);
        dly_d     = {dly_q[REDUCE_LATENCY-2:0], x_valid_q};
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d = {{(X_WIDTH - A_WIDTH){1'b0}}, a};
                    mplr_d  = k;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                // Bits leaving the top of mcand are always zero because the
                // product fits in X_WIDTH bits.
                acc_d   = sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    x_d       = sum;
                    x_valid_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and result register; reset aborts any multiply and flushes the strobe delay line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            x_valid_q <= 1'b0;
            dly_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            dly_q     <= dly_d;
        end
    end

    // Multiplier datapath registers; always reloaded on accept, so they need no reset.
    always_ff @(posedge clk) begin
        mcand_q <= mcand_d;
        acc_q   <= acc_d;
        mplr_q  <= mplr_d;
    end

endmodule

// File: tb/tb_scalar_mul_feeder.sv
// Testbench for scalar_mul_feeder: directed and random operand pairs checked
// against an arithmetic product model and a cycle-timing model of the strobes.
module tb_scalar_mul_feeder;

    localparam int AW = 256;
    localparam int KW = 44;
    localparam int XW = 300;
    localparam int RL = 45;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [KW-1:0] k;
    logic [XW-1:0] x;
    logic          x_valid;
    logic          busy;
    logic          res_valid;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int            acc_cyc[$];
    int            xv_cyc[$];
    int            rv_cyc[$];
    logic [XW-1:0] xv_val[$];
    logic [XW-1:0] exp_q[$];

    scalar_mul_feeder #(
        .A_WIDTH(AW), .K_WIDTH(KW), .X_WIDTH(XW), .REDUCE_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .k(k), .x(x), .x_valid(x_valid), .busy(busy), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log: accept edge number, x_valid cycles with x, res_valid cycles.
    always @(negedge clk) begin
        if (in_valid && in_ready && !reset) acc_cyc.push_back(cyc + 1);
        if (x_valid) begin
            xv_cyc.push_back(cyc);
            xv_val.push_back(x);
        end
        if (res_valid) rv_cyc.push_back(cyc);
    end

    function automatic logic [XW-1:0] prod(input logic [AW-1:0] aa, input logic [KW-1:0] kk);
        logic [XW-1:0] wa, wk;
        wa = XW'(aa);
        wk = XW'(kk);
        return wa * wk;
    endfunction

    task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [AW-1:0] aa, input logic [KW-1:0] kk);
        @(posedge clk); #1;
        a = aa;
        k = kk;
        in_valid = 1'b1;
        exp_q.push_back(prod(aa, kk));
        @(negedge clk);
        chk("in_ready_idle", XW'(in_ready), XW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("busy_in_mul", XW'(busy), XW'(1));
    endtask

    // Wait (bounded) for n res_valid pulses, then check counts, values and timing.
    task automatic drain(input int n, input string tag);
        int t;
        int m;
        t = 0;
        while (rv_cyc.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk({tag, "_n_accept"}, XW'(acc_cyc.size()), XW'(n));
        chk({tag, "_n_xvalid"}, XW'(xv_cyc.size()), XW'(n));
        chk({tag, "_n_resvalid"}, XW'(rv_cyc.size()), XW'(n));
        m = n;
        if (acc_cyc.size() < m) m = acc_cyc.size();
        if (xv_cyc.size() < m) m = xv_cyc.size();
        if (rv_cyc.size() < m) m = rv_cyc.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_x"}, xv_val[i], exp_q[i]);
            chk({tag, "_xvalid_lat"}, XW'(xv_cyc[i] - acc_cyc[i]), XW'(KW));
            chk({tag, "_resvalid_lat"}, XW'(rv_cyc[i] - xv_cyc[i]), XW'(RL));
        end
        if (n > 0) chk({tag, "_x_hold"}, x, exp_q[n-1]);
        acc_cyc.delete();
        xv_cyc.delete();
        rv_cyc.delete();
        xv_val.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [AW-1:0] p;
        logic [AW-1:0] ra;
        logic [KW-1:0] rk;
        int            t;

        p = 256'd104899928942039473597645237135751317405745389583683433800060134911610808289117;
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        k        = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", x, '0);
        chk("rst_x_valid", XW'(x_valid), '0);
        chk("rst_res_valid", XW'(res_valid), '0);
        chk("rst_busy", XW'(busy), '0);
        chk("rst_in_ready", XW'(in_ready), '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", XW'(in_ready), XW'(1));

        start_op(AW'(5), KW'(3));
        drain(1, "a5k3");

        start_op(p, KW'(1));
        drain(1, "p_k1");

        start_op('1, '1);
        drain(1, "max");

        start_op(AW'(123), KW'(0));
        drain(1, "k0");

        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < AW / 32; w++) ra[w*32 +: 32] = $urandom();
            rk = {12'($urandom()), 32'($urandom())};
            if (r == 3) rk = KW'($urandom_range(1, 15));
            start_op(ra, rk);
            drain(1, "rand");
        end

        // Three pairs offered with in_valid held high throughout.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < AW / 32; w++) ra[w*32 +: 32] = $urandom();
            rk = {12'($urandom()), 32'($urandom())};
            a = ra;
            k = rk;
            in_valid = 1'b1;
            exp_q.push_back(prod(ra, rk));
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("b2b_n_accept_early", XW'(acc_cyc.size()), XW'(3));
        if (acc_cyc.size() == 3) begin
            chk("b2b_spacing01", XW'(acc_cyc[1] - acc_cyc[0]), XW'(KW + 1));
            chk("b2b_spacing12", XW'(acc_cyc[2] - acc_cyc[1]), XW'(KW + 1));
        end
        drain(3, "b2b");

        // Reset 20 cycles into a multiply, with in_valid asserted during reset.
        start_op(AW'(777), KW'(999));
        exp_q.delete();
        repeat (18) @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", XW'(in_ready), XW'(1));
        chk("abort_busy", XW'(busy), '0);
        chk("abort_x_cleared", x, '0);
        repeat (120) @(negedge clk);
        chk("abort_n_xvalid", XW'(xv_cyc.size()), '0);
        chk("abort_n_resvalid", XW'(rv_cyc.size()), '0);
        chk("abort_n_accept", XW'(acc_cyc.size()), XW'(1));
        acc_cyc.delete();

        start_op(AW'(9), KW'(7));
        drain(1, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
